picorv32_mem_rr_arbiter: RTL

PICORV32_MEM_RR_ARBITER -- requirements
Module: picorv32_mem_rr_arbiter

---
 rtl/picorv32_arb_pkg.sv | 22 ++
 rtl/picorv32_rr_pick.sv | 64 ++++++
 rtl/picorv32_mem_rr_arbiter.sv | 124 ++++++++++++
 3 files changed

// File: rtl/picorv32_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | picorv32_arb_pkg                                                     |
// | Shared arbiter state encoding and core-index width helper.           |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package picorv32_arb_pkg;

  // Arbiter transaction phases
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_RESP  = 2'd2
  } arb_state_e;

  // Bits needed to name one of 'cores' ports (at least one bit)
  function automatic int core_idx_w(input int cores);
    return (cores > 1) ? $clog2(cores) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/picorv32_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | picorv32_rr_pick                                                     |
// | Combinational winner selection for the memory arbiter.               |
// | Default: round-robin, search starts just after last_grant_i, wraps.  |
// | PICORV32_ARB_FIXED_PRIO_EN defined: lowest requesting index wins.    |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module picorv32_rr_pick
  import picorv32_arb_pkg::*;
#(
  parameter int CORES_COUNT = 2
) (
  input  logic [CORES_COUNT-1:0]                req_i,
  input  logic [core_idx_w(CORES_COUNT)-1:0]    last_grant_i,
  output logic [core_idx_w(CORES_COUNT)-1:0]    winner_o,
  output logic                                  any_o
);

  localparam int IDX_W = core_idx_w(CORES_COUNT);

  logic [CORES_COUNT-1:0] w_shift;

  assign any_o = |req_i;

`ifdef PICORV32_ARB_FIXED_PRIO_EN
  // Priority order ignores history
  logic unused_last_grant;
  assign unused_last_grant = ^last_grant_i;

  // Lowest requesting index wins: scan high to low, last hit sticks
  always_comb begin
    winner_o = '0;
    w_shift  = '0;
    for (int c = CORES_COUNT - 1; c >= 0; c--) begin
      w_shift = req_i >> c;
      if (w_shift[0]) begin
        winner_o = IDX_W'(c);
      end
    end
  end
`else
  int w_dist;
  int w_best;

  // Winner is the requester at the smallest circular distance past last grant
  always_comb begin
    winner_o = '0;
    w_shift  = '0;
    w_dist   = 0;
    w_best   = CORES_COUNT;
    for (int c = 0; c < CORES_COUNT; c++) begin
      w_shift = req_i >> c;
      w_dist  = (c + 2 * CORES_COUNT - 1 - int'(last_grant_i)) % CORES_COUNT;
      if (w_shift[0] && (w_dist < w_best)) begin
        w_best   = w_dist;
        winner_o = IDX_W'(c);
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: rtl/picorv32_mem_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | picorv32_mem_rr_arbiter                                              |
// | Shares one native memory port toward the AXI adapter among           |
// | CORES_COUNT cores. One transaction at a time: IDLE -> GRANT -> RESP. |
// | Optional: PICORV32_ARB_FIXED_PRIO_EN selects fixed-priority pick.    |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module picorv32_mem_rr_arbiter
  import picorv32_arb_pkg::*;
#(
  parameter int CORES_COUNT = 2
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [CORES_COUNT-1:0]             mem_valid_i,
  input  logic [CORES_COUNT-1:0]             mem_instr_i,
  input  logic [31:0]                        mem_addr_i  [CORES_COUNT],
  input  logic [31:0]                        mem_wdata_i [CORES_COUNT],
  input  logic [3:0]                         mem_wstrb_i [CORES_COUNT],
  output logic [CORES_COUNT-1:0]             mem_ready_o,
  output logic [31:0]                        mem_rdata_o [CORES_COUNT],
  output logic                               mem_valid_o,
  output logic                               mem_instr_o,
  output logic [31:0]                        mem_addr_o,
  output logic [31:0]                        mem_wdata_o,
  output logic [3:0]                         mem_wstrb_o,
  input  logic                               mem_ready_i,
  input  logic [31:0]                        mem_rdata_i,
  output logic [core_idx_w(CORES_COUNT)-1:0] grant_id,
  output logic                               busy
);

  localparam int IDX_W = core_idx_w(CORES_COUNT);

  arb_state_e              state_q;
  logic                    valid_q;
  logic                    instr_q;
  logic [31:0]             addr_q;
  logic [31:0]             wdata_q;
  logic [3:0]              wstrb_q;
  logic [CORES_COUNT-1:0]  ready_q;
  logic [31:0]             rdata_q [CORES_COUNT];
  logic [IDX_W-1:0]        grant_q;
  logic [IDX_W-1:0]        last_grant_q;
  logic                    busy_q;

  logic [IDX_W-1:0]        w_winner;
  logic                    w_any;

  picorv32_rr_pick #(
    .CORES_COUNT (CORES_COUNT)
  ) u_pick (
    .req_i        (mem_valid_i),
    .last_grant_i (last_grant_q),
    .winner_o     (w_winner),
    .any_o        (w_any)
  );

  // Transaction FSM; all outputs are registered here
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      valid_q      <= 1'b0;
      instr_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      ready_q      <= '0;
      grant_q      <= '0;
      busy_q       <= 1'b0;
      last_grant_q <= IDX_W'(CORES_COUNT - 1);
      for (int c = 0; c < CORES_COUNT; c++) begin
        rdata_q[c] <= '0;
      end
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          // Stray mem_ready_i here is deliberately ignored
          if (w_any) begin
            grant_q <= w_winner;
            instr_q <= mem_instr_i[w_winner];
            addr_q  <= mem_addr_i[w_winner];
            wdata_q <= mem_wdata_i[w_winner];
            wstrb_q <= mem_wstrb_i[w_winner];
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          // Payload is latched; the core may drop valid without effect
          if (mem_ready_i) begin
            rdata_q[grant_q] <= mem_rdata_i;
            ready_q[grant_q] <= 1'b1;
            valid_q          <= 1'b0;
            state_q          <= ST_RESP;
          end
        end
        ST_RESP: begin
          ready_q      <= '0;
          busy_q       <= 1'b0;
          last_grant_q <= grant_q;
          state_q      <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_valid_o = valid_q;
  assign mem_instr_o = instr_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_wstrb_o = wstrb_q;
  assign mem_ready_o = ready_q;
  assign mem_rdata_o = rdata_q;
  assign grant_id    = grant_q;
  assign busy        = busy_q;

endmodule
`default_nettype wire
